// File: rtl/collision_pkg.sv
// Shared encoding for the collision detector: type bit indices and FSM states.
package collision_pkg;

  localparam int NUM_COLLISION_TYPES = 5;

  localparam int PLAYER_BORDER       = 0;
  localparam int ENEMY_BORDER        = 1;
  localparam int ENEMY_PLAYER_ZONE   = 2;
  localparam int MISSILE_HITS_ENEMY  = 3;
  localparam int MISSILE_HITS_PLAYER = 4;

  typedef enum logic [0:0] {
    WAIT_FIRST_FRAME = 1'b0,
    IN_FRAME         = 1'b1
  } state_e;

endpackage

// File: rtl/collision_type_tracker.sv
// Per-type tracker: sticky per-frame flag, first-overlap pulse and the
// previous-frame summary bit.
module collision_type_tracker (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic sof,
  input  logic raw,
  output logic pulse,
  output logic summary
);

  logic pulse_q, pulse_d;
  logic sticky_q, sticky_d;
  logic summary_q, summary_d;

  // Next-state logic: on start of frame the overlap seen this cycle opens the new frame.
  always_comb begin
    pulse_d   = 1'b0;
    sticky_d  = sticky_q;
    summary_d = summary_q;
    if (en) begin
      if (sof) begin
        summary_d = sticky_q;
        sticky_d  = raw;
        pulse_d   = raw;
      end else begin
        pulse_d  = raw & ~sticky_q;
        sticky_d = sticky_q | raw;
      end
    end else begin
      sticky_d = 1'b0;
    end
  end

  // Tracker state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pulse_q   <= 1'b0;
      sticky_q  <= 1'b0;
      summary_q <= 1'b0;
    end else begin
      pulse_q   <= pulse_d;
      sticky_q  <= sticky_d;
      summary_q <= summary_d;
    end
  end

  assign pulse   = pulse_q;
  assign summary = summary_q;

endmodule

// File: rtl/collision_detector.sv
// Detects per-pixel overlaps between drawing requests, pulses on the first
// overlap of each type per frame and publishes a per-frame summary.
module collision_detector
  import collision_pkg::*;
#(
  parameter int PIXEL_COUNT_WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           resetN,
  input  logic                           startOfFrame,
  input  logic                           game_active,
  input  logic                           playerDR,
  input  logic                           enemyDR,
  input  logic                           player_missileDR,
  input  logic                           enemy_missileDR,
  input  logic [0:1]                     bordersDR,
  output logic [NUM_COLLISION_TYPES-1:0] collision_pulse,
  output logic [NUM_COLLISION_TYPES-1:0] frame_collisions,
  output logic [PIXEL_COUNT_WIDTH-1:0]   hit_pixels,
  output logic                           summary_valid
);

  localparam logic [PIXEL_COUNT_WIDTH-1:0] CNT_MAX = {PIXEL_COUNT_WIDTH{1'b1}};

  state_e                         state_q, state_d;
  logic [PIXEL_COUNT_WIDTH-1:0]   hit_cnt_q, hit_cnt_d;
  logic [PIXEL_COUNT_WIDTH-1:0]   hit_pixels_q, hit_pixels_d;
  logic                           summary_valid_q, summary_valid_d;
  logic [NUM_COLLISION_TYPES-1:0] raw_s;
  logic                           en_s;

  // Raw overlaps this pixel, suppressed while the game is inactive.
  always_comb begin
    raw_s = '0;
    if (game_active) begin
      raw_s[PLAYER_BORDER]       = playerDR & bordersDR[0];
      raw_s[ENEMY_BORDER]        = enemyDR & bordersDR[0];
      raw_s[ENEMY_PLAYER_ZONE]   = enemyDR & bordersDR[1];
      raw_s[MISSILE_HITS_ENEMY]  = player_missileDR & enemyDR;
      raw_s[MISSILE_HITS_PLAYER] = enemy_missileDR & playerDR;
    end else begin
      raw_s = '0;
    end
  end

  assign en_s = (state_q == IN_FRAME);

  // Frame-sync state machine: nothing is tracked until the first full frame begins.
  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_FIRST_FRAME: begin
        if (startOfFrame) begin
          state_d = IN_FRAME;
        end else begin
          state_d = WAIT_FIRST_FRAME;
        end
      end
      IN_FRAME: state_d = IN_FRAME;
      default:  state_d = WAIT_FIRST_FRAME;
    endcase
  end

  // Saturating missile-hit pixel counter and summary publication.
  always_comb begin
    hit_cnt_d       = hit_cnt_q;
    hit_pixels_d    = hit_pixels_q;
    summary_valid_d = 1'b0;
    if (en_s) begin
      if (startOfFrame) begin
        hit_pixels_d    = hit_cnt_q;
        summary_valid_d = 1'b1;
        hit_cnt_d       = raw_s[MISSILE_HITS_ENEMY] ? PIXEL_COUNT_WIDTH'(1) : '0;
      end else if (raw_s[MISSILE_HITS_ENEMY] && (hit_cnt_q != CNT_MAX)) begin
        hit_cnt_d = hit_cnt_q + PIXEL_COUNT_WIDTH'(1);
      end else begin
        hit_cnt_d = hit_cnt_q;
      end
    end else begin
      hit_cnt_d = '0;
    end
  end

  // Top-level state registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q         <= WAIT_FIRST_FRAME;
      hit_cnt_q       <= '0;
      hit_pixels_q    <= '0;
      summary_valid_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      hit_cnt_q       <= hit_cnt_d;
      hit_pixels_q    <= hit_pixels_d;
      summary_valid_q <= summary_valid_d;
    end
  end

  for (genvar i = 0; i < NUM_COLLISION_TYPES; i++) begin : g_track
    collision_type_tracker u_track (
      .clk     (clk),
      .rst_n   (resetN),
      .en      (en_s),
      .sof     (startOfFrame),
      .raw     (raw_s[i]),
      .pulse   (collision_pulse[i]),
      .summary (frame_collisions[i])
    );
  end

  assign hit_pixels    = hit_pixels_q;
  assign summary_valid = summary_valid_q;

endmodule

// File: tb/tb_collision_detector.sv
// Directed table-driven bench for collision_detector plus multi-cycle corner sequences.
module tb_collision_detector;

  logic       clk;
  logic       resetN;
  logic       startOfFrame;
  logic       game_active;
  logic       playerDR;
  logic       enemyDR;
  logic       player_missileDR;
  logic       enemy_missileDR;
  logic [0:1] bordersDR;
  logic [4:0] collision_pulse;
  logic [4:0] frame_collisions;
  logic [7:0] hit_pixels;
  logic       summary_valid;

  int n_tests = 0;
  int n_fail  = 0;

  collision_detector #(.PIXEL_COUNT_WIDTH(8)) dut (
    .clk              (clk),
    .resetN           (resetN),
    .startOfFrame     (startOfFrame),
    .game_active      (game_active),
    .playerDR         (playerDR),
    .enemyDR          (enemyDR),
    .player_missileDR (player_missileDR),
    .enemy_missileDR  (enemy_missileDR),
    .bordersDR        (bordersDR),
    .collision_pulse  (collision_pulse),
    .frame_collisions (frame_collisions),
    .hit_pixels       (hit_pixels),
    .summary_valid    (summary_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       sof;
    logic       ga;
    logic       pdr;
    logic       edr;
    logic       pmdr;
    logic       emdr;
    logic [1:0] bdr;
    logic [4:0] exp_pulse;
    logic [4:0] exp_fc;
    logic [7:0] exp_hp;
    logic       exp_sv;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(input logic sof, input logic ga, input logic pdr,
                              input logic edr, input logic pmdr, input logic emdr,
                              input logic [1:0] bdr, input logic [4:0] ep,
                              input logic [4:0] ef, input logic [7:0] eh,
                              input logic esv);
    vec_t v;
    v.sof = sof; v.ga = ga; v.pdr = pdr; v.edr = edr; v.pmdr = pmdr; v.emdr = emdr;
    v.bdr = bdr; v.exp_pulse = ep; v.exp_fc = ef; v.exp_hp = eh; v.exp_sv = esv;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic sof, input logic ga, input logic pdr, input logic edr,
                       input logic pmdr, input logic emdr, input logic [1:0] bdr);
    startOfFrame     = sof;
    game_active      = ga;
    playerDR         = pdr;
    enemyDR          = edr;
    player_missileDR = pmdr;
    enemy_missileDR  = emdr;
    bordersDR        = bdr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [4:0] ep, input logic [4:0] ef,
                         input logic [7:0] eh, input logic esv);
    chk({tag, ".pulse"}, 32'(collision_pulse), 32'(ep));
    chk({tag, ".fc"},    32'(frame_collisions), 32'(ef));
    chk({tag, ".hp"},    32'(hit_pixels), 32'(eh));
    chk({tag, ".sv"},    32'(summary_valid), 32'(esv));
  endtask

  initial begin
    int pulse_cnt;
    // Vectors: inputs held for one cycle, expected outputs after that edge.
    //               sof  ga   pdr  edr  pmdr emdr bdr    pulse     fc        hp     sv
    vecs[0]  = mk(1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,2'b10, 5'b00000,5'b00000,8'd0, 1'b0); // overlap before first frame
    vecs[1]  = mk(1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b00, 5'b00000,5'b00000,8'd0, 1'b0);
    vecs[2]  = mk(1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,2'b00, 5'b00000,5'b00000,8'd0, 1'b0); // first SOF: no summary
    vecs[3]  = mk(1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,2'b10, 5'b00001,5'b00000,8'd0, 1'b0);
    vecs[4]  = mk(1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,2'b10, 5'b00000,5'b00000,8'd0, 1'b0);
    vecs[5]  = mk(1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,2'b10, 5'b00000,5'b00000,8'd0, 1'b0);
    vecs[6]  = mk(1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b00, 5'b00000,5'b00000,8'd0, 1'b0);
    vecs[7]  = mk(1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,2'b00, 5'b00000,5'b00001,8'd0, 1'b1);
    vecs[8]  = mk(1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,2'b10, 5'b00001,5'b00001,8'd0, 1'b0);
    vecs[9]  = mk(1'b0,1'b1,1'b1,1'b1,1'b0,1'b1,2'b10, 5'b10010,5'b00001,8'd0, 1'b0); // two types at once, bit0 already sticky
    vecs[10] = mk(1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00, 5'b00000,5'b00001,8'd0, 1'b0); // game inactive
    vecs[11] = mk(1'b0,1'b1,1'b0,1'b1,1'b1,1'b0,2'b00, 5'b01000,5'b00001,8'd0, 1'b0);
    vecs[12] = mk(1'b0,1'b1,1'b0,1'b1,1'b1,1'b0,2'b00, 5'b00000,5'b00001,8'd0, 1'b0);
    vecs[13] = mk(1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,2'b01, 5'b00100,5'b11011,8'd2, 1'b1); // SOF + overlap: new frame
    vecs[14] = mk(1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b00, 5'b00000,5'b11011,8'd2, 1'b0);
    vecs[15] = mk(1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,2'b00, 5'b00000,5'b00100,8'd0, 1'b1);
    vecs[16] = mk(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00, 5'b00000,5'b00000,8'd0, 1'b1); // summary while inactive

    resetN = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    tick();
    tick();
    chk_all("reset", 5'b00000, 5'b00000, 8'd0, 1'b0);
    resetN = 1'b1;

    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].sof, vecs[i].ga, vecs[i].pdr, vecs[i].edr,
            vecs[i].pmdr, vecs[i].emdr, vecs[i].bdr);
      tick();
      chk_all($sformatf("vec%0d", i), vecs[i].exp_pulse, vecs[i].exp_fc,
              vecs[i].exp_hp, vecs[i].exp_sv);
    end

    // 300 missile-enemy overlap pixels in one frame: one pulse, counter saturates.
    pulse_cnt = 0;
    for (int i = 0; i < 300; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00);
      tick();
      if (collision_pulse[3]) pulse_cnt++;
      if (i == 0) chk("sat.first_pulse", 32'(collision_pulse), 32'(5'b01000));
    end
    chk("sat.pulse_count", 32'(pulse_cnt), 32'd1);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    tick();
    chk_all("sat.summary", 5'b00000, 5'b01000, 8'd255, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    tick();
    chk("sat.sv_single", 32'(summary_valid), 32'd0);

    // Mid-frame reset with sticky bit3 set: everything clears, partial frame discarded.
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00);
    tick();
    chk("rst.pre_pulse", 32'(collision_pulse), 32'(5'b01000));
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    resetN = 1'b0;
    #1;
    chk_all("rst.async", 5'b00000, 5'b00000, 8'd0, 1'b0);
    tick();
    resetN = 1'b1;
    tick();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    tick();
    chk_all("rst.first_sof", 5'b00000, 5'b00000, 8'd0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    tick();
    tick();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    tick();
    chk_all("rst.second_sof", 5'b00000, 5'b00000, 8'd0, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
